// File: rtl/cost_update_ctrl.sv
// Sequencer for one cost-update pass over a register file: clear, load
// stay/temp candidate pairs, compare-and-replace each entry, then read all out.
module cost_update_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] num_states,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       clear,
    output logic       wr_en,
    output logic       intmp,
    output logic [3:0] in_sel,
    output logic       compare,
    output logic [3:0] com_sel,
    output logic [3:0] out_sel,
    output logic       rd_valid,
    output logic [3:0] rd_idx,
    output logic       rd_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_STAY,
        S_LOAD_TMP,
        S_COMPARE,
        S_READ,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] last_q, last_d;
    logic       rd_valid_q, rd_valid_d;
    logic [3:0] rd_idx_q, rd_idx_d;
    logic       rd_last_q, rd_last_d;
    logic       kill;

    assign kill = abort && (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        in_ready = 1'b0;
        done     = 1'b0;
        clear    = 1'b0;
        wr_en    = 1'b0;
        intmp    = 1'b0;
        in_sel   = '0;
        compare  = 1'b0;
        com_sel  = '0;
        out_sel  = '0;
        busy     = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    last_d  = num_states;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                clear   = 1'b1;
                state_d = S_LOAD_STAY;
            end
            S_LOAD_STAY: begin
                in_ready = 1'b1;
                in_sel   = idx_q;
                if (in_valid) begin
                    wr_en   = 1'b1;
                    state_d = S_LOAD_TMP;
                end
            end
            S_LOAD_TMP: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en   = 1'b1;
                    intmp   = 1'b1;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                compare = 1'b1;
                com_sel = idx_q;
                if (idx_q == last_q) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_LOAD_STAY;
                end
            end
            S_READ: begin
                out_sel = idx_q;
                if (idx_q == last_q) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every strobe and scrubs the register file on the way out.
        if (kill) begin
            in_ready = 1'b0;
            done     = 1'b0;
            clear    = 1'b1;
            wr_en    = 1'b0;
            intmp    = 1'b0;
            in_sel   = '0;
            compare  = 1'b0;
            com_sel  = '0;
            out_sel  = '0;
            idx_d    = '0;
            state_d  = S_IDLE;
        end
    end

    // Readout sideband lags out_sel by one cycle to line up with the registered file output.
    always_comb begin
        rd_valid_d = (state_q == S_READ) && !kill;
        rd_idx_d   = out_sel;
        rd_last_d  = (state_q == S_READ) && !kill && (idx_q == last_q);
    end

    assign rd_valid = rd_valid_q;
    assign rd_idx   = rd_idx_q;
    assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_cost_update_ctrl.sv
// Bench for cost_update_ctrl: register-file model driven by the DUT strobes,
// scoreboard of expected per-entry maxima, table of pass configurations.
module tb_cost_update_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] num_states = '0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, busy, done, clear, wr_en, intmp, compare;
    logic [3:0] in_sel, com_sel, out_sel, rd_idx;
    logic       rd_valid, rd_last;
    logic [7:0] din = '0;

    always #5 clk = ~clk;

    cost_update_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_states (num_states),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .clear      (clear),
        .wr_en      (wr_en),
        .intmp      (intmp),
        .in_sel     (in_sel),
        .compare    (compare),
        .com_sel    (com_sel),
        .out_sel    (out_sel),
        .rd_valid   (rd_valid),
        .rd_idx     (rd_idx),
        .rd_last    (rd_last)
    );

    typedef struct {
        int ns;
        int gap;
        int poke;
        int exp_lat;
    } vec_t;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
    } exp_t;

    exp_t       expq[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] rf_stay[16];
    logic [7:0] rf_tmp;
    logic [7:0] rd_model;
    logic [7:0] s_val[16];
    logic [7:0] t_val[16];
    logic [7:0] rd_seen[16];
    int         n_seen;
    int         wr_exp, cmp_exp, cur_ns;
    bit         prev_tmp, xfer, done_now;
    int         last_clr, last_wr, last_tmp, last_cmp, done_cyc, pass_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at the falling edge: checks outputs, then updates the register-file model.
    task automatic sample();
        exp_t e;
        xfer     = in_valid && in_ready;
        done_now = done;
        chk("strobe_excl", 32'(int'(wr_en) + int'(compare) + int'(clear) <= 1), 1);
        if (rd_valid) begin
            if (expq.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("rd_idx", rd_idx, e.idx);
                chk("rd_data", rd_model, e.val);
                if (n_seen < 16) begin
                    rd_seen[n_seen] = rd_model;
                    n_seen++;
                end
            end
            chk("rd_last", rd_last, rd_idx == cur_ns[3:0]);
        end
        if (done) begin
            done_cyc = cyc;
            chk("done_with_last", rd_valid && rd_last, 1);
        end
        if (!in_valid && in_ready) chk("stall_no_wr", wr_en, 0);
        if (clear) begin
            foreach (rf_stay[i]) rf_stay[i] = '0;
            rf_tmp   = '0;
            wr_exp   = 0;
            cmp_exp  = 0;
            last_clr = cyc;
        end
        if (wr_en && !intmp) begin
            chk("in_sel", in_sel, wr_exp);
            wr_exp++;
            rf_stay[in_sel] = din;
            last_wr = cyc;
        end
        if (wr_en && intmp) begin
            rf_tmp   = din;
            last_tmp = cyc;
        end
        if (compare) begin
            chk("com_sel", com_sel, cmp_exp);
            chk("cmp_after_tmp", prev_tmp, 1);
            cmp_exp++;
            if (rf_tmp > rf_stay[com_sel]) rf_stay[com_sel] = rf_tmp;
            last_cmp = cyc;
        end
        prev_tmp = wr_en && intmp;
        rd_model = rf_stay[out_sel];
    endtask

    task automatic samp();
        @(negedge clk);
        sample();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_pass(input int ns, input int gap, input int poke, input int abort_ent,
                            input bit rst_read, input int exp_lat);
        int   ent = 0;
        int   which = 0;
        int   waitc = 0;
        int   ab = 0;
        int   rs = 0;
        bit   fin = 0;
        exp_t e;
        cur_ns     = ns;
        done_cyc   = -1;
        n_seen     = 0;
        pass_start = cyc;
        num_states = 4'(ns);
        for (int k = 0; k < 400 && !fin; k++) begin
            start = (k == 0) || (poke > 0 && k == poke);
            if (ent > ns) begin
                in_valid = 1'b1;
                din      = '0;
            end else if (which == 1 && waitc < gap) begin
                in_valid = 1'b0;
                waitc++;
            end else begin
                in_valid = 1'b1;
                din      = (which == 1) ? t_val[ent] : s_val[ent];
            end
            samp();
            if (ab == 1) begin
                chk("abort_clear", clear, 1);
                chk("abort_compare", compare, 0);
                chk("abort_wr", wr_en, 0);
                chk("abort_ready", in_ready, 0);
                fin = 1;
            end
            if (rs == 2) begin
                chk("rst_outs", {busy, done, in_ready, clear, wr_en, intmp, compare, rd_valid,
                                 rd_last, in_sel, com_sel, out_sel, rd_idx}, 0);
                fin = 1;
            end
            if (rs == 1) rs = 2;
            if (rst_read && rs == 0 && rd_valid) rs = 1;
            if (xfer && ent <= ns && ab == 0) begin
                if (which == 0) begin
                    which = 1;
                    waitc = 0;
                end else begin
                    e.idx = 4'(ent);
                    e.val = (t_val[ent] > s_val[ent]) ? t_val[ent] : s_val[ent];
                    expq.push_back(e);
                    if (ent == abort_ent) ab = 2;
                    ent++;
                    which = 0;
                end
            end
            if (done_now) fin = 1;
            adv();
            abort = 1'b0;
            if (ab == 2) begin
                abort = 1'b1;
                ab    = 1;
            end
            reset = (rs == 1);
        end
        start    = 1'b0;
        abort    = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        if (ab == 0 && rs == 0) begin
            if (done_cyc < 0) chk("done_timeout", 0, 1);
            else chk("latency", done_cyc - pass_start, exp_lat);
            chk("queue_empty", expq.size(), 0);
        end else begin
            expq.delete();
        end
    endtask

    task automatic rand_data();
        foreach (s_val[i]) begin
            s_val[i] = 8'($urandom_range(0, 255));
            t_val[i] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{ns: 0,  gap: 0, poke: 0,  exp_lat: 6};
        vecs[1] = '{ns: 15, gap: 0, poke: 0,  exp_lat: 66};
        vecs[2] = '{ns: 3,  gap: 3, poke: 0,  exp_lat: 30};
        vecs[3] = '{ns: 2,  gap: 1, poke: 5,  exp_lat: 17};
        vecs[4] = '{ns: 7,  gap: 0, poke: 20, exp_lat: 34};

        adv();
        adv();
        @(negedge clk);
        chk("reset_outs", {busy, done, in_ready, clear, wr_en, intmp, compare, rd_valid,
                           rd_last, in_sel, com_sel, out_sel, rd_idx}, 0);
        adv();
        reset = 1'b0;

        start = 1'b1;
        abort = 1'b1;
        adv();
        start = 1'b0;
        abort = 1'b0;
        samp();
        chk("start_abort_idle", busy, 0);
        adv();

        s_val[0] = 8'd5;
        t_val[0] = 8'd9;
        run_pass(0, 0, 0, -1, 0, 6);
        chk("clr_cycle", last_clr - pass_start, 1);
        chk("wr_cycle", last_wr - pass_start, 2);
        chk("tmp_cycle", last_tmp - pass_start, 3);
        chk("cmp_cycle", last_cmp - pass_start, 4);
        chk("single_out", rd_seen[0], 9);

        foreach (vecs[i]) begin
            rand_data();
            run_pass(vecs[i].ns, vecs[i].gap, vecs[i].poke, -1, 0, vecs[i].exp_lat);
        end

        s_val[0] = 8'd3;
        s_val[1] = 8'd7;
        t_val[0] = 8'd5;
        t_val[1] = 8'd2;
        run_pass(1, 0, 0, -1, 0, 10);
        chk("rf_out0", rd_seen[0], 5);
        chk("rf_out1", rd_seen[1], 7);

        rand_data();
        run_pass(2, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("post_abort_busy", busy, 0);
            chk("post_abort_done", done, 0);
            chk("post_abort_rdv", rd_valid, 0);
            adv();
        end
        rand_data();
        run_pass(2, 0, 0, -1, 0, 14);

        rand_data();
        run_pass(3, 0, 0, -1, 1, 0);
        rand_data();
        run_pass(1, 0, 0, -1, 0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cost_update_ctrl.md
COST_UPDATE_CTRL -- requirements
Module: cost_update_ctrl

Interface
REQ-001 No parameters; all widths fixed (4-bit index, up to 16 states).
REQ-002 One clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin one update pass; honoured only in IDLE.
REQ-006 num_states  in  4  state count minus 1 (0 -> 1 state, 15 -> 16 states); sampled on accepted start.
REQ-007 abort  in  1  terminate pass; ignored in IDLE.
REQ-008 in_valid  in  1  upstream candidate cost present on the register-file data input.
REQ-009 in_ready  out  1  controller accepts candidate; a transfer occurs when in_valid and in_ready are both high.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse on pass completion.
REQ-012 clear  out  1  register-file clear strobe.
REQ-013 wr_en  out  1  register-file write enable.
REQ-014 intmp  out  1  write target is the temp register.
REQ-015 in_sel  out  4  write index.
REQ-016 compare  out  1  register-file compare-and-replace strobe.
REQ-017 com_sel  out  4  compare index.
REQ-018 out_sel  out  4  readout index.
REQ-019 rd_valid  out  1  register-file data output holds entry rd_idx this cycle.
REQ-020 rd_idx  out  4  index of the entry now on the register-file data output.
REQ-021 rd_last  out  1  rd_valid beat is the final entry.

Function
REQ-022 FSM states: IDLE, CLEAR, LOAD_STAY, LOAD_TMP, COMPARE, READ, DONE; a 4-bit counter idx tracks the current entry.
REQ-023 IDLE: start high and abort low -> CLEAR; N latched from num_states; idx set to 0.
REQ-024 CLEAR: clear=1 for exactly one cycle -> LOAD_STAY.
REQ-025 LOAD_STAY: in_ready=1; on transfer, same cycle wr_en=1, intmp=0, in_sel=idx -> LOAD_TMP; otherwise hold with wr_en=0.
REQ-026 LOAD_TMP: in_ready=1; on transfer, wr_en=1, intmp=1 -> COMPARE; otherwise hold.
REQ-027 COMPARE: compare=1, com_sel=idx, in_ready=0, for one cycle; if idx==N then idx=0 -> READ, else idx+1 -> LOAD_STAY.
REQ-028 READ: out_sel=idx, one entry per cycle; when idx==N -> DONE, else idx+1.
REQ-029 rd_valid, rd_idx and rd_last are registered copies of (READ, out_sel, idx==N), lagging by one cycle to match the registered register-file output.
REQ-030 DONE: done=1 for one cycle, coinciding with the rd_last beat -> IDLE.
REQ-031 wr_en, compare and clear are never high together; outside the states above, all strobes are 0 and the select outputs are 0.
REQ-032 With in_valid held high, done occurs 4N+2 cycles after the accepted start cycle, where N = num_states+1.
REQ-033 abort high in any non-IDLE state: clear=1, wr_en=0, compare=0, in_ready=0 that cycle; next state IDLE; no done; rd_valid is 0 from the next cycle.
REQ-034 start during busy is ignored; start and abort together in IDLE: start is ignored.
REQ-035 idx never exceeds N and never wraps past 15.

Reset
REQ-036 reset has priority over all inputs: next cycle state=IDLE, idx=0, rd_valid=0, rd_idx=0, rd_last=0, and all outputs 0 (busy, done, in_ready and all strobes included).
REQ-037 Reset mid-pass does not clear the register file; the next start clears it via CLEAR.

Verification
REQ-038 num_states=0, in_valid held high, candidates 5 then 9 -> CLEAR at cycle 1, wr in_sel=0 at cycle 2, intmp write at cycle 3, compare com_sel=0 at cycle 4, out_sel=0 at cycle 5, rd_valid/rd_last/done at cycle 6, output 9.
REQ-039 num_states=15, in_valid held high -> in_sel/com_sel sweep 0..15, rd_idx 0..15, done at cycle 66, no wrap.
REQ-040 in_valid low 3 cycles in LOAD_TMP -> in_ready stays 1, no wr_en, no compare until the transfer completes.
REQ-041 num_states=1, stay costs {3,7}, temp costs {5,2}, with a register-file model -> readout {5,7}.
REQ-042 abort during COMPARE of idx 1 -> clear=1, compare=0 that cycle; IDLE next cycle; no done; a following start runs the full pass correctly.
REQ-043 start pulsed mid-pass ignored; reset asserted in READ -> all outputs 0 next cycle, rd_valid 0.
